// File: rtl/path_mem_slave.sv
// Memory-side responder: grants req after a programmable delay, stores granted beats in order.
// Grant is registered (gnt_dly+2 edges after req); read data 1-cycle; gnt drops when full.
module path_mem_slave #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int EXPECT = 60
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        gnt_dly_i,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              done_o
);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] EXPECT_M1 = (ADDR_W+1)'(EXPECT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_dly;
  logic [3:0]          w_dly_nxt;
  logic                r_gnt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_ovf;
  logic                r_done;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_full;
  logic                w_we;
  logic                w_fill;

  assign w_full = (r_count == DEPTH_C);
  assign w_we   = (r_state == GRANT) && valid_i && !w_full;
  assign w_fill = w_we && (r_count == LAST_C);

  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    case (r_state)
      IDLE: begin
        if (req_i && !w_full) begin
          w_state_nxt = WAIT;
          w_dly_nxt   = gnt_dly_i;
        end
      end
      WAIT: begin
        if (!req_i) begin
          w_state_nxt = IDLE;
        end else if (r_dly == 4'd0) begin
          w_state_nxt = GRANT;
        end else begin
          w_dly_nxt = r_dly - 4'd1;
        end
      end
      GRANT: begin
        // The write that fills the last entry ends the grant on the same edge.
        if (!req_i || w_fill || w_full) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dly     <= 4'd0;
      r_gnt     <= 1'b0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_gnt   <= (w_state_nxt == GRANT);
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
      end
      r_done <= w_we && (r_count == EXPECT_M1);
      if (valid_i && w_full) begin
        r_ovf <= 1'b1;
      end
      if (rd_en_i) begin
        r_rd_data <= r_mem[rd_addr_i];
      end
    end
  end

  // Storage is never cleared; reset only suppresses the write on its edge.
  always_ff @(posedge clk) begin
    if (w_we && !rst) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  assign gnt_o      = r_gnt;
  assign rd_data_o  = r_rd_data;
  assign count_o    = r_count;
  assign full_o     = w_full;
  assign overflow_o = r_ovf;
  assign done_o     = r_done;

endmodule

// File: tb/tb_path_mem_slave.sv
// Directed bench for path_mem_slave: a vector table for the basic burst plus hand-written corner sequences.
module tb_path_mem_slave;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int EXPECT = 60;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        gnt_dly_i;
  logic              req_i;
  logic              gnt_o;
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              rd_en_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic [ADDR_W:0]   count_o;
  logic              full_o;
  logic              overflow_o;
  logic              done_o;

  int n_checks = 0;
  int n_pass   = 0;

  path_mem_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .EXPECT(EXPECT)) dut (
    .clk(clk), .rst(rst), .gnt_dly_i(gnt_dly_i), .req_i(req_i), .gnt_o(gnt_o),
    .valid_i(valid_i), .data_i(data_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .count_o(count_o), .full_o(full_o),
    .overflow_o(overflow_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic       valid;
    logic [7:0] data;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       exp_gnt;
    logic [6:0] exp_cnt;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tv [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_i = 1'b0; valid_i = 1'b0; rd_en_i = 1'b0; data_i = '0; rd_addr_i = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic get_grant(input logic [3:0] dly, input string name);
    int i;
    gnt_dly_i = dly; req_i = 1'b1; valid_i = 1'b0;
    i = 0;
    while (gnt_o !== 1'b1 && i < 40) begin
      step();
      i++;
    end
    chk({name, "_grant"}, 32'(gnt_o), 32'd1);
  endtask

  task automatic read_chk(input int addr, input logic [7:0] exp, input string name);
    rd_en_i = 1'b1; rd_addr_i = 6'(addr);
    step();
    rd_en_i = 1'b0;
    chk(name, 32'(rd_data_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_cnt;
    int done_beat;
    int beats;
    int seen;

    tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 7'd0, 8'h00};
    tv[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b1, 7'd0, 8'h00};
    tv[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 6'd0, 1'b1, 7'd1, 8'h00};
    tv[3]  = '{1'b1, 1'b1, 8'h22, 1'b0, 6'd0, 1'b1, 7'd2, 8'h00};
    tv[4]  = '{1'b1, 1'b1, 8'h33, 1'b0, 6'd0, 1'b1, 7'd3, 8'h00};
    tv[5]  = '{1'b1, 1'b1, 8'h44, 1'b0, 6'd0, 1'b1, 7'd4, 8'h00};
    tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd0, 1'b0, 7'd4, 8'h11};
    tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd1, 1'b0, 7'd4, 8'h22};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd2, 1'b0, 7'd4, 8'h33};
    tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 6'd3, 1'b0, 7'd4, 8'h44};
    tv[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0, 7'd4, 8'h44};

    // Reset state
    gnt_dly_i = 4'd0;
    do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_rd", 32'(rd_data_o), 32'd0);

    // Basic 4-beat burst with zero delay, then read-back
    for (int i = 0; i < 11; i++) begin
      req_i = tv[i].req; valid_i = tv[i].valid; data_i = tv[i].data;
      rd_en_i = tv[i].rd_en; rd_addr_i = tv[i].rd_addr;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt_o), 32'(tv[i].exp_gnt));
      chk($sformatf("vec%0d_cnt", i), 32'(count_o), 32'(tv[i].exp_cnt));
      chk($sformatf("vec%0d_rd", i), 32'(rd_data_o), 32'(tv[i].exp_rd));
    end

    // Delay 5: grant on the 7th edge; changing the delay mid-WAIT has no effect
    gnt_dly_i = 4'd5; req_i = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      if (e == 1) gnt_dly_i = 4'd0;
      chk($sformatf("dly5_e%0d", e), 32'(gnt_o), (e == 7) ? 32'd1 : 32'd0);
    end
    req_i = 1'b0;
    step();
    chk("dly5_drop", 32'(gnt_o), 32'd0);

    // Request abandoned during WAIT never yields a grant
    gnt_dly_i = 4'd5; req_i = 1'b1;
    step(); step(); step();
    req_i = 1'b0;
    seen = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (gnt_o) seen++;
    end
    chk("abort_no_gnt", 32'(seen), 32'd0);
    gnt_dly_i = 4'd0; req_i = 1'b1;
    step();
    chk("abort_idle_e1", 32'(gnt_o), 32'd0);
    step();
    chk("abort_idle_e2", 32'(gnt_o), 32'd1);
    req_i = 1'b0;
    step();
    chk("abort_count", 32'(count_o), 32'd4);

    // Two bursts of 30; second has a gap after every beat
    do_reset();
    done_cnt = 0; done_beat = -1; beats = 0;
    get_grant(4'd0, "b1");
    for (int i = 0; i < 30; i++) begin
      valid_i = 1'b1; data_i = pat(beats);
      step();
      beats++;
      if (done_o) begin done_cnt++; done_beat = beats; end
    end
    valid_i = 1'b0; req_i = 1'b0;
    step();
    if (done_o) begin done_cnt++; done_beat = -2; end
    get_grant(4'd2, "b2");
    for (int j = 0; j < 30; j++) begin
      valid_i = 1'b1; data_i = pat(beats);
      step();
      beats++;
      if (done_o) begin done_cnt++; done_beat = beats; end
      valid_i = 1'b0;
      step();
      if (done_o) begin done_cnt++; done_beat = -3; end
    end
    req_i = 1'b0;
    step();
    if (done_o) done_cnt++;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("done_at_beat", 32'(done_beat), 32'd60);
    chk("b_count", 32'(count_o), 32'd60);
    chk("b_full", 32'(full_o), 32'd0);
    for (int k = 0; k < 60; k++) begin
      read_chk(k, pat(k), $sformatf("b_rd%0d", k));
    end

    // Fill to DEPTH, then no grant and overflow on a forced beat
    get_grant(4'd0, "fill");
    for (int b = 60; b < 64; b++) begin
      valid_i = 1'b1; data_i = pat(b);
      step();
    end
    valid_i = 1'b0;
    chk("fill_gnt_drop", 32'(gnt_o), 32'd0);
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd64);
    seen = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      if (gnt_o) seen++;
    end
    chk("full_no_gnt", 32'(seen), 32'd0);
    valid_i = 1'b1; data_i = 8'hAA;
    step();
    valid_i = 1'b0; req_i = 1'b0;
    chk("ovf_set", 32'(overflow_o), 32'd1);
    step(); step();
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd64);
    read_chk(0, pat(0), "ovf_mem0");

    // Reset in the middle of a granted transfer
    do_reset();
    chk("rst2_ovf", 32'(overflow_o), 32'd0);
    chk("rst2_full", 32'(full_o), 32'd0);
    chk("rst2_rd", 32'(rd_data_o), 32'd0);
    get_grant(4'd0, "mid");
    valid_i = 1'b1; data_i = 8'hE1; step();
    data_i = 8'hE2; step();
    rst = 1'b1; data_i = 8'h5A;
    step();
    rst = 1'b0; valid_i = 1'b0; req_i = 1'b0;
    chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
    read_chk(2, pat(2), "mid_no_write");
    get_grant(4'd0, "post");
    valid_i = 1'b1; data_i = 8'h10; step();
    data_i = 8'h20; step();
    valid_i = 1'b0; req_i = 1'b0;
    step();
    chk("post_count", 32'(count_o), 32'd2);
    read_chk(0, 8'h10, "post_rd0");
    read_chk(1, 8'h20, "post_rd1");

    // Read-before-write on the same address and edge
    do_reset();
    get_grant(4'd0, "rbw");
    valid_i = 1'b1; data_i = 8'h77; rd_en_i = 1'b1; rd_addr_i = 6'd0;
    step();
    chk("rbw_old", 32'(rd_data_o), 32'h10);
    valid_i = 1'b0; req_i = 1'b0;
    step();
    rd_en_i = 1'b0;
    chk("rbw_new", 32'(rd_data_o), 32'h77);
    chk("rbw_count", 32'(count_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
